// File: rtl/typing_ctrl_if.sv
// Keystroke / prompt-ROM / renderer signal bundle for typing_ctrl.
// The master side is the surrounding system (keyboard decoder, prompt ROM,
// frame timing, renderer). The slave side is the controller itself.
interface typing_ctrl_if;
    logic        key_valid;
    logic [7:0]  key_code;
    logic        key_ready;
    logic        frame_tick;
    logic [11:0] prompt_idx;
    logic [6:0]  prompt_char;
    logic [31:0] correct_index_x;
    logic [31:0] correct_index_y;
    logic [15:0] errors;
    logic        done;
    logic        err_flash;

    modport master (
        output key_valid, key_code, frame_tick, prompt_char,
        input  key_ready, prompt_idx, correct_index_x, correct_index_y,
               errors, done, err_flash
    );

    modport slave (
        input  key_valid, key_code, frame_tick, prompt_char,
        output key_ready, prompt_idx, correct_index_x, correct_index_y,
               errors, done, err_flash
    );
endinterface

// File: rtl/typing_ctrl.sv
// typing_ctrl: typing-progress sequencer for the prompt renderer.
// Accepts keystrokes, fetches the expected character from the prompt ROM,
// advances the cursor on a match and counts mismatches. Cursor position and
// the error highlight are published to the renderer only on frame_tick.
// Optional feature macro: TYPING_BACKSPACE_EN (8'h08 moves the cursor back).
module typing_ctrl #(
    parameter int COLS       = 64,
    parameter int ROWS       = 4,
    parameter int PROMPT_LEN = 256,
    parameter int ERR_FRAMES = 8
) (
    input  logic        clk,
    input  logic        reset,
    typing_ctrl_if.slave bus
);
    localparam int CB = $clog2(COLS);

    // Geometry must fit the prompt and reduce % and / to bit slicing.
    if (PROMPT_LEN > COLS * ROWS || (COLS & (COLS - 1)) != 0 ||
        (ROWS & (ROWS - 1)) != 0) begin : g_bad_cfg
        $error("typing_ctrl: invalid COLS/ROWS/PROMPT_LEN");
    end

    typedef enum logic [1:0] {READY, FETCH, CMP, DONE} state_t;

    state_t      state, state_nx;
    logic [11:0] idx;
    logic [7:0]  key_r;
    logic [6:0]  exp_r;
    logic        err_pend;
    logic [3:0]  flash_cnt;
    logic [15:0] err_cnt;
    logic        done_r;
    logic        err_flash_r;
    logic [31:0] shadow_x, shadow_y;

    logic accept, match, last, is_bs, miss, enter;

    assign bus.key_ready       = (state == READY) || (state == DONE);
    assign accept              = bus.key_valid && bus.key_ready;
    assign enter               = bus.key_code == 8'h0D;
    assign bus.prompt_idx      = idx;
    assign bus.errors          = err_cnt;
    assign bus.done            = done_r;
    assign bus.err_flash       = err_flash_r;
    assign bus.correct_index_x = shadow_x;
    assign bus.correct_index_y = shadow_y;

    // Bit 7 set can never match: the prompt is 7-bit ASCII.
    assign match = !key_r[7] && (key_r[6:0] == exp_r);
    assign last  = (13'(idx) + 13'd1) == 13'(PROMPT_LEN);

`ifdef TYPING_BACKSPACE_EN
    assign is_bs = key_r == 8'h08;
`else
    assign is_bs = 1'b0;
`endif

    assign miss = (state == CMP) && !is_bs && !match;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= READY;
        else       state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            READY: if (accept) state_nx = FETCH;
            FETCH: state_nx = CMP;
            CMP: begin
                if (!is_bs && match && last) state_nx = DONE;
                else                         state_nx = READY;
            end
            DONE:  if (accept && enter) state_nx = READY;
            default: state_nx = READY;
        endcase
    end

    // Capture registers, cursor, error count and completion flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_r   <= '0;
            exp_r   <= '0;
            idx     <= '0;
            err_cnt <= '0;
            done_r  <= 1'b0;
        end else begin
            if (state == READY && accept) key_r <= bus.key_code;
            if (state == FETCH)           exp_r <= bus.prompt_char;
            if (state == CMP) begin
                if (is_bs) begin
                    if (idx != 12'd0) idx <= idx - 12'd1;
                end else if (match) begin
                    idx <= idx + 12'd1;
                    if (last) done_r <= 1'b1;
                end else if (err_cnt != 16'hFFFF) begin
                    err_cnt <= err_cnt + 16'd1;
                end
            end
            // Keys other than Enter are swallowed while done.
            if (state == DONE && accept && enter) begin
                idx     <= '0;
                err_cnt <= '0;
                done_r  <= 1'b0;
            end
        end
    end

    // Frame-aligned shadow of the cursor; pre-update idx if CMP coincides.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_x <= '0;
            shadow_y <= '0;
        end else if (bus.frame_tick) begin
            shadow_x <= 32'(idx & 12'(COLS - 1));
            shadow_y <= 32'(idx >> CB);
        end
    end

    // Error highlight: a pending error (re)loads the frame counter on the
    // next tick; a mismatch in the same cycle as that tick stays pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_pend    <= 1'b0;
            flash_cnt   <= '0;
            err_flash_r <= 1'b0;
        end else begin
            if (bus.frame_tick) begin
                if (err_pend) begin
                    err_pend    <= 1'b0;
                    flash_cnt   <= 4'(ERR_FRAMES);
                    err_flash_r <= 1'b1;
                end else if (flash_cnt != 4'd0) begin
                    flash_cnt <= flash_cnt - 4'd1;
                    if (flash_cnt == 4'd1) err_flash_r <= 1'b0;
                end
            end
            if (miss) err_pend <= 1'b1;
        end
    end
endmodule
